// File: rtl/alien_row_drawer_pkg.sv
// ---------------------------------------------------------------------------
// alien_row_drawer_pkg
// Shared definitions for the alien row drawer: screen geometry, VGA adapter
// field widths, colour constants, the FSM state encoding and the helper that
// limits the fall offset to the visible range.
// ---------------------------------------------------------------------------
package alien_row_drawer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int OFFSET_W = 6;

    // Deepest row offset the formation may fall to before the game is lost.
    localparam logic [OFFSET_W-1:0] MAX_OFFSET_Y = 6'd40;

    localparam logic [COL_W-1:0] COLOUR_ALIEN = 3'b010;
    localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_DRAW  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HALT  = 3'd4
    } drawState_t;

    // Offsets beyond the deepest row are treated as the deepest row.
    function automatic logic [OFFSET_W-1:0] clampOffsetY(input logic [OFFSET_W-1:0] rawY);
        return (rawY > MAX_OFFSET_Y) ? MAX_OFFSET_Y : rawY;
    endfunction

endpackage

// File: rtl/alien_sprite_rom.sv
// ---------------------------------------------------------------------------
// alien_sprite_rom
// Combinational 8x6 alien bitmap. Rows 6 and 7 of the 3-bit row address are
// outside the sprite and read as background.
// Ports:
//   px_i    in  3  column within the sprite (0 = left)
//   py_i    in  3  row within the sprite (0 = top)
//   pixel_o out 1  1 = alien pixel, 0 = transparent
// ---------------------------------------------------------------------------
module alien_sprite_rom (
    input  logic [2:0] px_i,
    input  logic [2:0] py_i,
    output logic       pixel_o
);

    logic [7:0] rowBits;

    // The bitmap is left/right symmetric, so column bit order does not matter.
    always_comb begin
        rowBits = 8'b0000_0000;
        case (py_i)
            3'd0:    rowBits = 8'b0001_1000;
            3'd1:    rowBits = 8'b0011_1100;
            3'd2:    rowBits = 8'b0111_1110;
            3'd3:    rowBits = 8'b1101_1011;
            3'd4:    rowBits = 8'b1111_1111;
            3'd5:    rowBits = 8'b0010_0100;
            default: rowBits = 8'b0000_0000;
        endcase
    end

    assign pixel_o = rowBits[px_i];

endmodule

// File: rtl/alien_row_drawer.sv
// ---------------------------------------------------------------------------
// alien_row_drawer
// Redraws the alien formation row whenever the fall counter moves it: first
// paints background over every sprite box at the previous row offset, then
// paints the living aliens at the new offset, one VGA adapter pixel per cycle.
// Ports:
//   Clock      in  1         system clock
//   Reset      in  1         synchronous, active-high
//   drawReq    in  1         one-cycle redraw request from the fall counter
//   offsetY    in  6         new row offset (values above 40 act as 40)
//   alienAlive in  N_ALIENS  bit k set -> alien k is drawn
//   gameOver   in  1         level; freezes the drawer until Reset
//   x          out 8         pixel x
//   y          out 7         pixel y
//   colour     out 3         pixel colour
//   plot       out 1         pixel write strobe
//   busy       out 1         redraw in progress
//   done       out 1         one-cycle pulse after the last pixel
// ---------------------------------------------------------------------------
module alien_row_drawer
    import alien_row_drawer_pkg::*;
#(
    parameter int               N_ALIENS  = 8,
    parameter int               ALIEN_W   = 8,
    parameter int               ALIEN_H   = 6,
    parameter int               SPACING   = 4,
    parameter int               X_ORIGIN  = 16,
    parameter int               Y_ORIGIN  = 8,
    parameter logic [COL_W-1:0] FG_COLOUR = COLOUR_ALIEN,
    parameter logic [COL_W-1:0] BG_COLOUR = COLOUR_BLACK
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                drawReq,
    input  logic [OFFSET_W-1:0] offsetY,
    input  logic [N_ALIENS-1:0] alienAlive,
    input  logic                gameOver,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COL_W-1:0]    colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    drawState_t          state_q;
    logic [2:0]          k_q;
    logic [2:0]          px_q;
    logic [2:0]          py_q;
    logic                primed_q;
    logic [OFFSET_W-1:0] oldY_q;
    logic [OFFSET_W-1:0] newY_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COL_W-1:0]    colour_q;
    logic                plot_q;
    logic                busy_q;
    logic                done_q;

    logic [OFFSET_W-1:0] rowY_d;
    logic [8:0]          xFull_d;
    logic [7:0]          yFull_d;
    logic                lastPixel_d;
    logic                spriteBit;
    logic                unusedBits;

    alien_sprite_rom spriteRom (
        .px_i    (px_q),
        .py_i    (py_q),
        .pixel_o (spriteBit)
    );

    // Screen position of the pixel addressed by the sweep counters. Sums are
    // formed wider than the adapter fields; the parameters keep them on screen,
    // so the top bits are dropped.
    always_comb begin
        rowY_d      = (state_q == ST_ERASE) ? oldY_q : newY_q;
        xFull_d     = 9'(X_ORIGIN) + 9'(k_q) * 9'(ALIEN_W + SPACING) + 9'(px_q);
        yFull_d     = 8'(Y_ORIGIN) + 8'(rowY_d) + 8'(py_q);
        lastPixel_d = (k_q  == 3'(N_ALIENS - 1)) &&
                      (py_q == 3'(ALIEN_H - 1))  &&
                      (px_q == 3'(ALIEN_W - 1));
    end

    assign unusedBits = xFull_d[8] ^ yFull_d[7];

    // Redraw sequencer. The first ERASE cycle only arms the sweep, so busy
    // rises one cycle ahead of the first pixel. The sweep counters wrap to zero
    // on the last pixel, which leaves them ready for the next pass.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
            primed_q <= 1'b0;
            oldY_q   <= '0;
            newY_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (gameOver || (state_q == ST_HALT)) begin
            state_q <= ST_HALT;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= (state_q == ST_ERASE) || (state_q == ST_DRAW);

            if ((state_q == ST_ERASE && primed_q) || state_q == ST_DRAW) begin
                if (px_q == 3'(ALIEN_W - 1)) begin
                    px_q <= '0;
                    if (py_q == 3'(ALIEN_H - 1)) begin
                        py_q <= '0;
                        k_q  <= (k_q == 3'(N_ALIENS - 1)) ? 3'd0 : k_q + 3'd1;
                    end else begin
                        py_q <= py_q + 3'd1;
                    end
                end else begin
                    px_q <= px_q + 3'd1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (drawReq) begin
                        newY_q   <= clampOffsetY(offsetY);
                        k_q      <= '0;
                        px_q     <= '0;
                        py_q     <= '0;
                        primed_q <= 1'b0;
                        state_q  <= ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else begin
                        x_q      <= xFull_d[X_W-1:0];
                        y_q      <= yFull_d[Y_W-1:0];
                        colour_q <= BG_COLOUR;
                        plot_q   <= 1'b1;
                        if (lastPixel_d) begin
                            state_q <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    x_q      <= xFull_d[X_W-1:0];
                    y_q      <= yFull_d[Y_W-1:0];
                    colour_q <= FG_COLOUR;
                    plot_q   <= alienAlive[k_q] && spriteBit;
                    if (lastPixel_d) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    oldY_q  <= newY_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alien_row_drawer.sv
// ---------------------------------------------------------------------------
// tb_alien_row_drawer
// Directed bench for the alien row drawer. A cycle-indexed reference model
// predicts every output from the time elapsed since the accepted request;
// hand-computed totals and ranges pin the model for each scenario.
// ---------------------------------------------------------------------------
module tb_alien_row_drawer;

    localparam int N_AL   = 8;
    localparam int AW     = 8;
    localparam int AH     = 6;
    localparam int GAP    = 4;
    localparam int XO     = 16;
    localparam int YO     = 8;
    localparam int PASS   = N_AL * AW * AH;
    localparam int DONE_T = 2 * PASS + 2;

    logic       Clock      = 1'b0;
    logic       Reset      = 1'b1;
    logic       drawReq    = 1'b0;
    logic [5:0] offsetY    = 6'd0;
    logic [7:0] alienAlive = 8'h00;
    logic       gameOver   = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles since the accepted request (-1 = idle).
    int         mT          = -1;
    int         mOld        = 0;
    int         mNew        = 0;
    bit         mHalt       = 1'b0;
    bit         mResetSeen  = 1'b0;
    logic [7:0] mAlive      = 8'h00;
    int         sinceAccept = 0;

    string spriteRows [6] = '{"...##...", "..####..", ".######.",
                              "##.##.##", "########", "..#..#.."};

    // Observed statistics of the current scenario.
    int bgPlots, fgPlots, bgYMin, bgYMax, fgYMin, fgYMax, fgXMin, fgXMax;
    int a7Plots, a7XMin, doneCount, doneRel, haltPlots, plotCount;

    alien_row_drawer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .drawReq    (drawReq),
        .offsetY    (offsetY),
        .alienAlive (alienAlive),
        .gameOver   (gameOver),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #10 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearStats();
        bgPlots = 0; fgPlots = 0; a7Plots = 0; doneCount = 0; doneRel = -1;
        haltPlots = 0; plotCount = 0;
        bgYMin = 999; bgYMax = -1; fgYMin = 999; fgYMax = -1;
        fgXMin = 999; fgXMax = -1; a7XMin = 999;
    endtask

    // Advance the model using the inputs the DUT samples at this edge.
    task automatic modelStep();
        mResetSeen = Reset;
        sinceAccept++;
        if (Reset) begin
            mT = -1; mOld = 0; mHalt = 1'b0;
        end else if (mHalt || gameOver) begin
            mHalt = 1'b1; mT = -1;
        end else begin
            if (mT >= 0) begin
                mT++;
                if (mT == DONE_T) mOld = mNew;
                if (mT > DONE_T) mT = -1;
            end
            if (mT < 0 && drawReq) begin
                mT = 0;
                mNew = (offsetY > 6'd40) ? 40 : int'(offsetY);
                sinceAccept = 0;
            end
        end
        mAlive = alienAlive;
    endtask

    task automatic compareCycle();
        int j, k, py, px, eX, eY, eCol, ePlot, eBusy, eDone;
        bit erase;
        ePlot = 0; eX = 0; eY = 0; eCol = 0;
        eBusy = (mT >= 1 && mT <= DONE_T - 1) ? 1 : 0;
        eDone = (mT == DONE_T) ? 1 : 0;
        if (mT >= 2 && mT <= DONE_T - 1) begin
            j = mT - 2;
            erase = (j < PASS);
            if (!erase) j = j - PASS;
            k  = j / (AW * AH);
            py = (j % (AW * AH)) / AW;
            px = j % AW;
            eX = XO + k * (AW + GAP) + px;
            eY = YO + (erase ? mOld : mNew) + py;
            eCol = erase ? 0 : 2;
            ePlot = (erase || (mAlive[k] && spriteRows[py][px] == "#")) ? 1 : 0;
        end
        checkOutput("plot", 32'(plot), ePlot);
        checkOutput("busy", 32'(busy), eBusy);
        checkOutput("done", 32'(done), eDone);
        if (ePlot == 1) begin
            checkOutput("x", 32'(x), eX);
            checkOutput("y", 32'(y), eY);
            checkOutput("colour", 32'(colour), eCol);
        end
        if (mResetSeen) begin
            checkOutput("resetX", 32'(x), 0);
            checkOutput("resetY", 32'(y), 0);
            checkOutput("resetColour", 32'(colour), 0);
        end
        if (plot === 1'b1) begin
            plotCount++;
            if (mHalt) haltPlots++;
            if (colour == 3'b000) begin
                bgPlots++;
                if (int'(y) < bgYMin) bgYMin = int'(y);
                if (int'(y) > bgYMax) bgYMax = int'(y);
            end else begin
                fgPlots++;
                if (int'(y) < fgYMin) fgYMin = int'(y);
                if (int'(y) > fgYMax) fgYMax = int'(y);
                if (int'(x) < fgXMin) fgXMin = int'(x);
                if (int'(x) > fgXMax) fgXMax = int'(x);
                if (x >= 8'd96) begin
                    a7Plots++;
                    if (int'(x) < a7XMin) a7XMin = int'(x);
                end
            end
        end
        if (done === 1'b1) begin
            doneCount++;
            doneRel = sinceAccept;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            modelStep();
            #1;
            compareCycle();
        end
    endtask

    task automatic applyStimulus(input logic [5:0] offs, input logic [7:0] alive);
        clearStats();
        offsetY    = offs;
        alienAlive = alive;
        drawReq    = 1'b1;
        tick(1);
        drawReq    = 1'b0;
    endtask

    initial begin
        clearStats();
        $display("[TB] reset and idle");
        tick(3);
        checkOutput("rstPlot", 32'(plot), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstX", 32'(x), 0);
        Reset = 1'b0;
        tick(20);
        checkOutput("idlePlots", plotCount, 0);

        $display("[TB] full row at offset 0");
        applyStimulus(6'd0, 8'hFF);
        tick(DONE_T + 2);
        checkOutput("t2BgPlots", bgPlots, 384);
        checkOutput("t2BgYMin", bgYMin, 8);
        checkOutput("t2BgYMax", bgYMax, 13);
        checkOutput("t2FgPlots", fgPlots, 224);
        checkOutput("t2FgXMin", fgXMin, 16);
        checkOutput("t2FgXMax", fgXMax, 107);
        checkOutput("t2A7Plots", a7Plots, 28);
        checkOutput("t2A7XMin", a7XMin, 100);
        checkOutput("t2DoneRel", doneRel, 770);
        checkOutput("t2DoneCount", doneCount, 1);

        $display("[TB] move to offset 1");
        applyStimulus(6'd1, 8'hFF);
        tick(DONE_T + 2);
        checkOutput("t3BgYMin", bgYMin, 8);
        checkOutput("t3BgYMax", bgYMax, 13);
        checkOutput("t3FgYMin", fgYMin, 9);
        checkOutput("t3FgYMax", fgYMax, 14);

        $display("[TB] single alive alien");
        applyStimulus(6'd1, 8'h01);
        tick(DONE_T + 2);
        checkOutput("t4BgPlots", bgPlots, 384);
        checkOutput("t4FgPlots", fgPlots, 28);
        checkOutput("t4FgXMin", fgXMin, 16);
        checkOutput("t4FgXMax", fgXMax, 23);
        checkOutput("t4DoneRel", doneRel, 770);

        $display("[TB] request while busy");
        applyStimulus(6'd2, 8'hFF);
        tick(299);
        offsetY = 6'd5;
        drawReq = 1'b1;
        tick(1);
        drawReq = 1'b0;
        tick(DONE_T + 2 - 300);
        checkOutput("t5DoneCount", doneCount, 1);
        checkOutput("t5FgYMin", fgYMin, 10);
        checkOutput("t5FgYMax", fgYMax, 15);

        $display("[TB] game over mid draw");
        applyStimulus(6'd3, 8'hFF);
        tick(400);
        gameOver = 1'b1;
        tick(50);
        drawReq = 1'b1;
        tick(1);
        drawReq = 1'b0;
        tick(10);
        gameOver = 1'b0;
        tick(5);
        checkOutput("t6DoneCount", doneCount, 0);
        checkOutput("t6HaltPlots", haltPlots, 0);
        checkOutput("t6Busy", 32'(busy), 0);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(2);

        $display("[TB] reset mid draw");
        applyStimulus(6'd4, 8'hFF);
        tick(DONE_T + 2);
        applyStimulus(6'd6, 8'hFF);
        tick(500);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        checkOutput("t7Plot", 32'(plot), 0);
        checkOutput("t7Busy", 32'(busy), 0);
        checkOutput("t7Y", 32'(y), 0);
        tick(2);
        applyStimulus(6'd7, 8'hFF);
        tick(DONE_T + 2);
        checkOutput("t7BgYMin", bgYMin, 8);
        checkOutput("t7BgYMax", bgYMax, 13);
        checkOutput("t7FgYMin", fgYMin, 15);
        checkOutput("t7FgYMax", fgYMax, 20);

        $display("[TB] clamped offset");
        applyStimulus(6'd63, 8'hFF);
        tick(DONE_T + 2);
        checkOutput("t8BgYMin", bgYMin, 15);
        checkOutput("t8FgYMin", fgYMin, 48);
        checkOutput("t8FgYMax", fgYMax, 53);
        checkOutput("t8FgPlots", fgPlots, 224);
        checkOutput("t8DoneRel", doneRel, 770);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
